// File: rtl/fpu_dispatch.sv
// ============================================================================
// Module   : fpu_dispatch
// Brief    : Single-outstanding initiator for the FPU order/accepted/done
//            handshake; a watchdog turns a hung unit into an error completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_dispatch #(
  parameter int NUNITS = 5,
  parameter int OPW    = 3,
  parameter int TAGW   = 5,
  parameter int TOW    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [OPW-1:0]       in_op_i,
  input  logic [31:0]          in_rs1_i,
  input  logic [31:0]          in_rs2_i,
  input  logic [TAGW-1:0]      in_tag_i,
  output logic [NUNITS-1:0]    unit_order_o,
  input  logic [NUNITS-1:0]    unit_accepted_i,
  input  logic [NUNITS-1:0]    unit_done_i,
  input  logic [32*NUNITS-1:0] unit_rd_i,
  output logic [31:0]          unit_rs1_o,
  output logic [31:0]          unit_rs2_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_rd_o,
  output logic [TAGW-1:0]      out_tag_o,
  output logic                 out_err_o
);

  localparam logic [1:0]     c_idle   = 2'd0;
  localparam logic [1:0]     c_issue  = 2'd1;
  localparam logic [1:0]     c_wait   = 2'd2;
  localparam logic [1:0]     c_resp   = 2'd3;
  localparam logic [TOW-1:0] c_wd_max = '1;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [NUNITS-1:0] sel_q, sel_d;
  logic [NUNITS-1:0] order_q, order_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;
  logic [TOW-1:0]    wd_q, wd_d;

  logic [NUNITS-1:0] op_hot_w;
  logic [31:0]       sel_rd_w;
  logic              acc_w;
  logic              done_w;

  // An out-of-range op decodes to all zeros, which is what flags it illegal.
  always_comb begin
    op_hot_w = '0;
    for (int i = 0; i < NUNITS; i++) begin
      op_hot_w[i] = (in_op_i == OPW'(i));
    end
  end

  always_comb begin
    sel_rd_w = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (sel_q[i]) sel_rd_w = unit_rd_i[32*i +: 32];
    end
  end

  assign acc_w  = |(unit_accepted_i & sel_q);
  assign done_w = |(unit_done_i & sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    order_d = order_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    tag_d   = tag_q;
    rd_d    = rd_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      c_idle: begin
        if (in_valid_i && ready_q) begin
          sel_d = op_hot_w;
          rs1_d = in_rs1_i;
          rs2_d = in_rs2_i;
          tag_d = in_tag_i;
          wd_d  = '0;
          if (|op_hot_w) begin
            order_d = op_hot_w;
            state_d = c_issue;
          end else begin
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = c_resp;
          end
        end
      end
      c_issue: begin
        if (acc_w) begin
          order_d = '0;
          wd_d    = '0;
          if (done_w) begin
            rd_d    = sel_rd_w;
            err_d   = 1'b0;
            state_d = c_resp;
          end else begin
            state_d = c_wait;
          end
        end else if (wd_q == c_wd_max) begin
          order_d = '0;
          rd_d    = '1;
          err_d   = 1'b1;
          state_d = c_resp;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      c_wait: begin
        if (done_w) begin
          rd_d    = sel_rd_w;
          err_d   = 1'b0;
          state_d = c_resp;
        end else if (wd_q == c_wd_max) begin
          rd_d    = '1;
          err_d   = 1'b1;
          state_d = c_resp;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        if (out_ready_i) state_d = c_idle;
      end
    endcase
    ready_d = (state_d == c_idle);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= c_idle;
      ready_q <= 1'b0;
      sel_q   <= '0;
      order_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      order_q <= order_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign in_ready_o   = ready_q;
  assign unit_order_o = order_q;
  assign unit_rs1_o   = rs1_q;
  assign unit_rs2_o   = rs2_q;
  assign out_valid_o  = (state_q == c_resp);
  assign out_rd_o     = rd_q;
  assign out_tag_o    = tag_q;
  assign out_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_dispatch.sv
// ============================================================================
// Module   : tb_fpu_dispatch
// Brief    : Directed self-checking bench for fpu_dispatch (TOW=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_dispatch;

  localparam int NU = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [31:0]   in_rs1, in_rs2;
  logic [4:0]    in_tag;
  logic [NU-1:0] unit_order, unit_accepted, unit_done;
  logic [159:0]  unit_rd;
  logic [31:0]   unit_rs1, unit_rs2;
  logic          out_valid, out_ready;
  logic [31:0]   out_rd;
  logic [4:0]    out_tag;
  logic          out_err;

  fpu_dispatch #(.NUNITS(NU), .OPW(3), .TAGW(5), .TOW(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_tag_i(in_tag),
    .unit_order_o(unit_order), .unit_accepted_i(unit_accepted),
    .unit_done_i(unit_done), .unit_rd_i(unit_rd),
    .unit_rs1_o(unit_rs1), .unit_rs2_o(unit_rs2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rd_o(out_rd), .out_tag_o(out_tag), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the outstanding request and what it must complete with.
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  tag;
    logic [31:0] rd;
    logic        err;
  } req_t;

  req_t req_next;
  req_t q[$];
  bit   exp_rdy = 1'b0;

  // Unit responder configuration.
  int          cfg_u = 0, cfg_acc = 0, cfg_done = 0;
  bit          cfg_never = 1'b0;
  logic [31:0] cfg_rd = '0;
  bit          stray_en = 1'b0;
  int          stray_u = 0;
  bit          kill = 1'b0;
  int          acc_cnt = 0, dcnt = 0;
  bit          waitd = 1'b0;

  initial begin
    unit_accepted = '0;
    unit_done     = '0;
    unit_rd       = '0;
    forever begin
      @(negedge clk);
      unit_accepted = '0;
      unit_done     = '0;
      for (int i = 0; i < NU; i++) unit_rd[32*i +: 32] = 32'hA5A50000 + 32'(i);
      if (kill) begin
        waitd   = 1'b0;
        acc_cnt = 0;
      end else if (waitd) begin
        if (dcnt == 0) begin
          waitd = 1'b0;
          unit_done[cfg_u] = 1'b1;
          unit_rd[32*cfg_u +: 32] = cfg_rd;
        end else begin
          dcnt--;
        end
      end else if (cfg_u < NU && unit_order[cfg_u]) begin
        if (acc_cnt < cfg_acc) begin
          acc_cnt++;
        end else begin
          acc_cnt = 0;
          unit_accepted[cfg_u] = 1'b1;
          if (!cfg_never) begin
            if (cfg_done == 0) begin
              unit_done[cfg_u] = 1'b1;
              unit_rd[32*cfg_u +: 32] = cfg_rd;
            end else begin
              waitd = 1'b1;
              dcnt  = cfg_done - 1;
            end
          end
        end
      end else begin
        acc_cnt = 0;
      end
      if (stray_en) begin
        unit_done[stray_u] = 1'b1;
        unit_rd[32*stray_u +: 32] = 32'hBAD0BAD0;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    req_t        e;
    logic [4:0]  eord;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, exp_rdy);
      chk("order_onehot", $countones(unit_order) <= 1, 1);
      if (q.size() == 0) begin
        chk("idle_order", unit_order, 0);
        chk("idle_valid", out_valid, 0);
      end else begin
        e = q[0];
        eord = (e.op < 3'(NU)) ? (5'b1 << e.op) : 5'b0;
        if (unit_order != 0) begin
          chk("order_sel", unit_order, eord);
          chk("unit_rs1", unit_rs1, e.rs1);
          chk("unit_rs2", unit_rs2, e.rs2);
        end
        if (out_valid) begin
          chk("m_out_rd", out_rd, e.rd);
          chk("m_out_tag", out_tag, e.tag);
          chk("m_out_err", out_err, e.err);
        end
      end
      if (!rstn) begin
        q.delete();
        exp_rdy = 1'b0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(req_next);
        exp_rdy = (q.size() == 0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] tag, input logic [31:0] erd, input logic eerr);
    bit ok = 1'b0;
    req_next = '{op: op, rs1: rs1, rs2: rs2, tag: tag, rd: erd, err: eerr};
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("handshake", ok, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [4:0] tag, input logic [31:0] erd, input logic eerr,
                     input int acc, input int dn, input bit never, input int rdly,
                     input int exp_ord, input int exp_lat);
    int first = -1;
    int ord = 0;
    bit fin = 1'b0;
    cfg_u = int'(op); cfg_acc = acc; cfg_done = dn; cfg_never = never; cfg_rd = erd;
    @(posedge clk); #1;
    issue(op, rs1, rs2, tag, erd, eerr);
    for (int j = 0; j < 60 && !fin; j++) begin
      @(negedge clk);
      if (unit_order != 0) ord++;
      if (out_valid && first < 0) begin
        first = j;
        chk("out_rd", out_rd, erd);
        chk("out_tag", out_tag, tag);
        chk("out_err", out_err, eerr);
      end
      if (out_valid && out_ready) fin = 1'b1;
      @(posedge clk); #1;
      out_ready = (first >= 0) && (j + 1 - first >= rdly);
    end
    out_ready = 1'b0;
    chk("order_cycles", ord, exp_ord);
    chk("latency", first, exp_lat);
    chk("complete", fin, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    out_ready = 1'b0;
    req_next = '{op: 3'd0, rs1: 32'd0, rs2: 32'd0, tag: 5'd0, rd: 32'd0, err: 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_order", unit_order, 0);
    chk("rst_rs1", unit_rs1, 0);
    chk("rst_rs2", unit_rs2, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_err", out_err, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // fsqrt(4.0) = 2.0
    run(3'd4, 32'h40800000, 32'h0, 5'd3, 32'h40000000, 1'b0, 0, 9, 1'b0, 1, 1, 10);
    // fsub 1.0 - 2.0 = -1.0 with a slow accept
    run(3'd1, 32'h3F800000, 32'h40000000, 5'd7, 32'hBF800000, 1'b0, 4, 3, 1'b0, 1, 5, 8);
    // fmul 2.0 * 3.0 = 6.0 under backpressure with stray done on unit 0
    stray_u = 0; stray_en = 1'b1;
    run(3'd2, 32'h40000000, 32'h40400000, 5'd12, 32'h40C00000, 1'b0, 0, 2, 1'b0, 6, 1, 3);
    stray_en = 1'b0;
    // illegal op
    run(3'd6, 32'h12345678, 32'h9ABCDEF0, 5'd9, 32'h0, 1'b1, 0, 0, 1'b0, 1, 0, 0);
    // timeout: accepted, never done
    run(3'd3, 32'h3F800000, 32'h0, 5'd21, 32'hFFFFFFFF, 1'b1, 0, 0, 1'b1, 1, 1, 17);
    // stale done while idle
    @(posedge clk); #1;
    stray_u = 3; stray_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_en = 1'b0;
    // fdiv 6.0 / 2.0 = 3.0
    run(3'd3, 32'h40C00000, 32'h40000000, 5'd22, 32'h40400000, 1'b0, 1, 1, 1'b0, 1, 2, 3);
    // fadd 1.0 + 1.0 = 2.0, done together with accept
    run(3'd0, 32'h3F800000, 32'h3F800000, 5'd30, 32'h40000000, 1'b0, 2, 0, 1'b0, 1, 3, 3);

    // reset in the middle of WAIT
    cfg_u = 4; cfg_acc = 0; cfg_done = 9; cfg_never = 1'b0; cfg_rd = 32'h40000000;
    @(posedge clk); #1;
    issue(3'd4, 32'h40800000, 32'h0, 5'd3, 32'h40000000, 1'b0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0; kill = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1; kill = 1'b0;
    @(negedge clk);
    chk("mid_rst_order", unit_order, 0);
    chk("mid_rst_rs1", unit_rs1, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rd", out_rd, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_err", out_err, 0);
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);
    run(3'd4, 32'h40800000, 32'h0, 5'd3, 32'h40000000, 1'b0, 0, 9, 1'b0, 1, 1, 10);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
